// File: rtl/fu_mult_sequencer_pkg.sv
// fu_mult_sequencer_pkg: shared ALU FunctionSelect encodings and sequencer state codes
package fu_mult_sequencer_pkg;
  localparam logic [3:0] FS_PASS_A = 4'b0000;
  localparam logic [3:0] FS_INC_A  = 4'b0001;
  localparam logic [3:0] FS_ADD    = 4'b0010;
  localparam logic [3:0] FS_ADD_C  = 4'b0011;
  localparam logic [3:0] FS_SUB    = 4'b0101;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/fu_mult_sequencer_port_mux.sv
// fu_port_mux: selects which requester drives the shared ALU ports
module fu_port_mux #(
  parameter int DATA_WIDTH    = 32,
  parameter int SHIFTER_WIDTH = 5
) (
  input  logic                     i_sel,
  input  logic [DATA_WIDTH-1:0]    i_byp_a,
  input  logic [DATA_WIDTH-1:0]    i_byp_b,
  input  logic [3:0]               i_byp_fs,
  input  logic [SHIFTER_WIDTH-1:0] i_byp_sh,
  input  logic [DATA_WIDTH-1:0]    i_seq_a,
  input  logic [DATA_WIDTH-1:0]    i_seq_b,
  input  logic [3:0]               i_seq_fs,
  input  logic [SHIFTER_WIDTH-1:0] i_seq_sh,
  output logic [DATA_WIDTH-1:0]    o_a,
  output logic [DATA_WIDTH-1:0]    o_b,
  output logic [3:0]               o_fs,
  output logic [SHIFTER_WIDTH-1:0] o_sh
);
  // bypass owns the ALU whenever it is granted, otherwise the sequencer drives it
  always_comb begin
    o_a  = i_sel ? i_byp_a  : i_seq_a;
    o_b  = i_sel ? i_byp_b  : i_seq_b;
    o_fs = i_sel ? i_byp_fs : i_seq_fs;
    o_sh = i_sel ? i_byp_sh : i_seq_sh;
  end
endmodule

// File: rtl/fu_mult_sequencer.sv
// fu_mult_sequencer: shift-add multiply sequenced through a shared ALU's adder
module fu_mult_sequencer
  import fu_mult_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int SHIFTER_WIDTH = 5,
  parameter int CNT_WIDTH     = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  output logic                      busy,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product,
  input  logic [DATA_WIDTH-1:0]     byp_a,
  input  logic [DATA_WIDTH-1:0]     byp_b,
  input  logic [3:0]                byp_fs,
  input  logic [SHIFTER_WIDTH-1:0]  byp_sh,
  output logic                      byp_grant,
  output logic [DATA_WIDTH-1:0]     fu_a,
  output logic [DATA_WIDTH-1:0]     fu_b,
  output logic [3:0]                fu_fs,
  output logic [SHIFTER_WIDTH-1:0]  fu_sh,
  input  logic [DATA_WIDTH-1:0]     fu_result,
  input  logic                      fu_carry
);
  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_m;
  logic [DATA_WIDTH-1:0]   r_p_hi;
  logic [DATA_WIDTH-1:0]   r_p_lo;
  logic [CNT_WIDTH-1:0]    r_count;
  logic [2*DATA_WIDTH-1:0] r_product;
  logic [2*DATA_WIDTH-1:0] w_shift;
  logic                    w_last;
  logic [DATA_WIDTH-1:0]   w_addend;
  // partial product shifted right by one with the adder carry entering at the top
  assign w_shift   = {fu_carry, fu_result, r_p_lo[DATA_WIDTH-1:1]};
  assign w_last    = r_count == CNT_WIDTH'(DATA_WIDTH - 1);
  assign w_addend  = r_p_lo[0] ? r_m : '0;
  assign byp_grant = r_state == ST_IDLE;
  assign busy      = !byp_grant;
  assign done      = r_state == ST_DONE;
  assign product   = r_product;
  fu_port_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SHIFTER_WIDTH(SHIFTER_WIDTH)
  ) u_mux (
    .i_sel   (byp_grant),
    .i_byp_a (byp_a),
    .i_byp_b (byp_b),
    .i_byp_fs(byp_fs),
    .i_byp_sh(byp_sh),
    .i_seq_a (r_p_hi),
    .i_seq_b (w_addend),
    .i_seq_fs(FS_ADD),
    .i_seq_sh('0),
    .o_a     (fu_a),
    .o_b     (fu_b),
    .o_fs    (fu_fs),
    .o_sh    (fu_sh)
  );
  // control FSM and datapath: accept in IDLE, one multiplier bit per RUN cycle, pulse DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_m       <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        r_m     <= op_a;
        r_p_hi  <= '0;
        r_p_lo  <= op_b;
        r_count <= '0;
        r_state <= ST_RUN;
      end
    end else if (r_state == ST_RUN) begin
      {r_p_hi, r_p_lo} <= w_shift;
      r_count          <= r_count + 1'b1;
      if (w_last) begin
        r_product <= w_shift;
        r_state   <= ST_DONE;
      end
    end else begin
      r_state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_fu_mult_sequencer.sv
// tb_fu_mult_sequencer: scoreboard bench with a behavioural ALU beside the sequencer
module tb_fu_mult_sequencer;
  import fu_mult_sequencer_pkg::*;
  localparam int W  = 32;
  localparam int SW = 5;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  op_a = '0, op_b = '0, byp_a = '0, byp_b = '0;
  logic [3:0]    byp_fs = '0;
  logic [SW-1:0] byp_sh = '0;
  logic          busy, done, byp_grant, fu_carry;
  logic [2*W-1:0] product;
  logic [W-1:0]  fu_a, fu_b, fu_result;
  logic [3:0]    fu_fs;
  logic [SW-1:0] fu_sh;
  logic [W:0]    alu_sum;
  fu_mult_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .byp_a(byp_a), .byp_b(byp_b), .byp_fs(byp_fs), .byp_sh(byp_sh),
    .byp_grant(byp_grant), .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs), .fu_sh(fu_sh),
    .fu_result(fu_result), .fu_carry(fu_carry)
  );
  always #5 clk = ~clk;
  always_comb begin
    alu_sum   = {1'b0, fu_a} + {1'b0, fu_b};
    fu_result = (fu_fs == FS_ADD) ? alu_sum[W-1:0] : fu_a;
    fu_carry  = (fu_fs == FS_ADD) ? alu_sum[W] : 1'b0;
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [2*W-1:0] prod;
    int             at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_pass = 0;
  int n_total = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) check("unexpected_done", {63'b0, done}, 64'd0);
      else begin
        mon_e = sb.pop_front();
        check("product", product, mon_e.prod);
        check("done_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end
  end
  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp, input bit push);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{exp, cyc + W});
    start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || busy); i++) @(negedge clk);
    @(negedge clk);
    n_total++;
    if (sb.size() != 0 || busy) $display("FAIL drain_timeout: pending %0d busy %0b required 0 0", sb.size(), busy);
    else n_pass++;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_grant", 64'(byp_grant), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    byp_a = 32'd1; byp_b = 32'd2; byp_fs = FS_ADD; byp_sh = 5'd3;
    #1;
    check("byp_fu_a", 64'(fu_a), 64'd1);
    check("byp_fu_b", 64'(fu_b), 64'd2);
    check("byp_fu_fs", 64'(fu_fs), 64'(FS_ADD));
    check("byp_fu_sh", 64'(fu_sh), 64'd3);
    check("byp_result", 64'(fu_result), 64'd3);
    @(negedge clk);
    mult(32'd3, 32'd5, 64'd15, 1'b1);
    byp_fs = FS_PASS_A;
    @(negedge clk);
    check("run_busy", 64'(busy), 64'd1);
    check("run_done", 64'(done), 64'd0);
    check("run_grant", 64'(byp_grant), 64'd0);
    check("run_fu_fs", 64'(fu_fs), 64'(FS_ADD));
    check("run_fu_sh", 64'(fu_sh), 64'd0);
    drain();
    mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
    drain();
    mult(32'd0, 32'h12345678, 64'd0, 1'b1);
    drain();
    mult(32'd9, 32'd11, 64'd99, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1; op_a = 32'd7;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("ignored_start_product", product, 64'd99);
    mult(32'd2, 32'd3, 64'd6, 1'b1);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    check("done_seen", 64'(done), 64'd1);
    start = 1'b1; op_a = 32'd4; op_b = 32'd5;
    @(posedge clk);
    @(posedge clk);
    #1;
    sb.push_back('{64'd20, cyc + W});
    start = 1'b0;
    drain();
    mult(32'd5, 32'd6, 64'd30, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    rst = 1'b0;
    mult(32'd6, 32'd7, 64'd42, 1'b1);
    drain();
    repeat (40) @(negedge clk);
    check("final_product", product, 64'd42);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
